// File: rtl/wb_ic_pkg.sv
// Shared types and constants for the Wishbone shared-bus interconnect.
// State encoding and arbitration-mode selectors live here so the arbiter and top agree.
package wb_ic_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_OWN  = 2'd1,
        WB_ERR  = 2'd2
    } wb_state_e;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational grant selection: round-robin after the last winner, or lowest index first.
// Only consulted while the bus is idle; the caller registers the result.
import wb_ic_pkg::*;

module wb_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic          mode_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW-1:0] idx;
    logic          found;

    // Scan N candidates; in round-robin mode the scan starts just past last_i and wraps.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int off = 1; off <= N; off++) begin
            if (mode_i == ARB_FIXED) begin
                idx = IW'(off - 1);
            end else begin
                idx = IW'((int'(last_i) + off) % N);
            end
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/wb_interconnect.sv
// Shared-bus Wishbone interconnect: one owner at a time, address decode to one slave,
// zero-latency response routing, and error termination on decode miss or stall timeout.
import wb_ic_pkg::*;

module wb_interconnect #(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 4,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]  wb_m_addr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]  wb_m_data_i,
    input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]   wb_m_sel_i,
    input  logic [NUM_MASTERS-1:0]                wb_m_we_i,
    input  logic [NUM_MASTERS-1:0]                wb_m_stb_i,
    input  logic [NUM_MASTERS-1:0]                wb_m_cyc_i,
    output logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]  wb_m_data_o,
    output logic [NUM_MASTERS-1:0]                wb_m_ack_o,
    output logic [NUM_MASTERS-1:0]                wb_m_err_o,
    output logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0]   wb_s_addr_o,
    output logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]   wb_s_data_o,
    output logic [NUM_SLAVES*WB_SEL_WIDTH-1:0]    wb_s_sel_o,
    output logic [NUM_SLAVES-1:0]                 wb_s_we_o,
    output logic [NUM_SLAVES-1:0]                 wb_s_stb_o,
    output logic [NUM_SLAVES-1:0]                 wb_s_cyc_o,
    input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]   wb_s_data_i,
    input  logic [NUM_SLAVES-1:0]                 wb_s_ack_i,
    output logic [NUM_MASTERS-1:0]                grant_o,
    output logic                                  timeout_o
);

    localparam int IW = idx_width(NUM_MASTERS);
    localparam int SW = idx_width(NUM_SLAVES);
    localparam logic [1:0] ST_IDLE = WB_IDLE;
    localparam logic [1:0] ST_OWN  = WB_OWN;
    localparam logic [1:0] ST_ERR  = WB_ERR;
    localparam logic ARB_SEL = (ARB_MODE == 0) ? ARB_RR : ARB_FIXED;
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          last_q, last_d;
    logic [15:0]            stall_q, stall_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [IW-1:0]          arb_idx;

    logic [WB_ADDR_WIDTH-1:0] own_addr;
    logic [WB_DATA_WIDTH-1:0] own_data;
    logic [WB_SEL_WIDTH-1:0]  own_sel;
    logic                     own_we, own_stb, own_cyc;

    logic                     match;
    logic [SW-1:0]            sel_idx;
    logic [NUM_SLAVES-1:0]    sel_oh;
    logic [WB_DATA_WIDTH-1:0] sel_rdata;
    logic                     active, ack_now;

    wb_rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_arb (
        .req_i     (wb_m_cyc_i),
        .mode_i    (ARB_SEL),
        .last_i    (last_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    // With no owner every mux input is zero, so the broadcast buses idle at 0.
    always_comb begin
        own_addr = '0;
        own_data = '0;
        own_sel  = '0;
        own_we   = 1'b0;
        own_stb  = 1'b0;
        own_cyc  = 1'b0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (grant_q[m]) begin
                own_addr = wb_m_addr_i[m*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
                own_data = wb_m_data_i[m*WB_DATA_WIDTH +: WB_DATA_WIDTH];
                own_sel  = wb_m_sel_i[m*WB_SEL_WIDTH +: WB_SEL_WIDTH];
                own_we   = wb_m_we_i[m];
                own_stb  = wb_m_stb_i[m];
                own_cyc  = wb_m_cyc_i[m];
            end
        end
    end

    // Descending scan so the lowest matching slave index is the one left standing.
    always_comb begin
        match   = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
        for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
            if ((own_addr & SLAVE_MASK[s*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) ==
                SLAVE_BASE[s*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) begin
                match   = 1'b1;
                sel_idx = SW'(s);
            end
        end
        if (match) begin
            sel_oh[sel_idx] = 1'b1;
        end
    end

    assign active    = (state_q == ST_OWN) && own_cyc;
    assign sel_rdata = wb_s_data_i[sel_idx*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    assign ack_now   = active && own_stb && match && wb_s_ack_i[sel_idx];

    assign wb_s_addr_o = {NUM_SLAVES{own_addr}};
    assign wb_s_data_o = {NUM_SLAVES{own_data}};
    assign wb_s_sel_o  = {NUM_SLAVES{own_sel}};
    assign wb_s_we_o   = {NUM_SLAVES{own_we}};
    assign wb_s_cyc_o  = active ? sel_oh : '0;
    assign wb_s_stb_o  = (active && own_stb) ? sel_oh : '0;

    always_comb begin
        wb_m_data_o = '0;
        wb_m_ack_o  = '0;
        wb_m_err_o  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (grant_q[m]) begin
                wb_m_ack_o[m] = ack_now;
                wb_m_err_o[m] = (state_q == ST_ERR);
                if (active && match) begin
                    wb_m_data_o[m*WB_DATA_WIDTH +: WB_DATA_WIDTH] = sel_rdata;
                end
            end
        end
    end

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

    // An ack in the limit cycle wins over the timeout because it is tested first.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        stall_d   = stall_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (|wb_m_cyc_i) begin
                    grant_d = arb_gnt;
                    last_d  = arb_idx;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    stall_d = '0;
                end else if (own_stb && !match) begin
                    state_d = ST_ERR;
                    stall_d = '0;
                end else if (!own_stb || ack_now) begin
                    stall_d = '0;
                end else if (stall_q == STALL_LIMIT) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b1;
                    stall_d   = '0;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_OWN;
                stall_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                stall_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IW'(NUM_MASTERS - 1);
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
